// File: rtl/duty_ramp_pkg.sv
// Shared types and constants for the duty ramp block and the downstream pwm.
package duty_ramp_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/duty_ramp_if.sv
// Target handshake and duty/status bus between a duty source and duty_ramp.
interface duty_ramp_if;
  import duty_ramp_pkg::*;

  logic [DUTY_W-1:0] target;
  logic              target_valid;
  logic              target_ready;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;

  modport master (
    output target, target_valid,
    input  target_ready, duty, busy, done
  );

  modport slave (
    input  target, target_valid,
    output target_ready, duty, busy, done
  );

endinterface

// File: rtl/duty_ramp_prescaler.sv
// Ramp tick divider: counts enabled clocks 0..RAMP_DIV-1 and flags the last one.
module ramp_prescaler #(
  parameter int RAMP_DIV = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // tick is qualified by enable so a period-synced ramp steps on the period edge
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// Slew-limited duty generator feeding pwm.duty. Optional macro
// DUTY_RAMP_PERIOD_SYNC_EN makes the prescaler count PWM periods via period_start.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int RAMP_DIV = 256,
  parameter int STEP     = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef DUTY_RAMP_PERIOD_SYNC_EN
  input  logic period_start,
`endif
  duty_ramp_if.slave bus
);

  localparam logic [DUTY_W:0] STEP9 = (DUTY_W+1)'(STEP);

  state_t            state;
  logic [DUTY_W-1:0] tgt;
  logic [DUTY_W-1:0] duty_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic [DUTY_W-1:0] eff_tgt;
  logic              up;
  logic [DUTY_W:0]   diff9;
  logic [DUTY_W:0]   step9;
  logic [DUTY_W:0]   sum9;
  logic [DUTY_W-1:0] next_duty;
  logic              tick;
  logic              pre_en;
  logic              pre_clr;
  logic              exit_now;

  // Ready is unconditional, so every valid edge is an accept.
  assign accept           = bus.target_valid;
  assign bus.target_ready = 1'b1;
  assign bus.duty         = duty_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // A target accepted on a tick edge steers that same tick.
  always_comb begin
    eff_tgt = accept ? bus.target : tgt;
    up      = eff_tgt > duty_q;
    diff9   = up ? ({1'b0, eff_tgt} - {1'b0, duty_q})
                 : ({1'b0, duty_q} - {1'b0, eff_tgt});
    step9   = (diff9 < STEP9) ? diff9 : STEP9;
    sum9    = up ? ({1'b0, duty_q} + step9) : ({1'b0, duty_q} - step9);
    // step never exceeds diff, so the carry cannot set; clamp keeps it obviously safe
    next_duty = sum9[DUTY_W] ? DUTY_MAX : sum9[DUTY_W-1:0];
  end

  always_comb begin
    exit_now = 1'b0;
    if (state == RAMP) begin
      if (tick)
        exit_now = (next_duty == eff_tgt);
      else
        exit_now = accept && (bus.target == duty_q);
    end
  end

`ifdef DUTY_RAMP_PERIOD_SYNC_EN
  assign pre_en = (state == RAMP) && period_start;
`else
  assign pre_en = (state == RAMP);
`endif
  assign pre_clr = (state == IDLE) || exit_now;

  ramp_prescaler #(
    .RAMP_DIV (RAMP_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tgt    <= '0;
      duty_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept)
        tgt <= bus.target;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.target == duty_q) begin
              done_q <= 1'b1;
            end else begin
              state  <= RAMP;
              busy_q <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (tick)
            duty_q <= next_duty;
          if (exit_now) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp (RAMP_DIV=4, STEP=16); adds a period-sync
// instance when DUTY_RAMP_PERIOD_SYNC_EN is defined.
module tb_duty_ramp;
  import duty_ramp_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  duty_ramp_if dif();

  always #5 clk = ~clk;

`ifdef DUTY_RAMP_PERIOD_SYNC_EN
  logic ps_one = 1'b1;
  logic period_start = 1'b0;
  int   ps_cnt = 0;
  duty_ramp_if sif();

  duty_ramp #(.RAMP_DIV(DIV), .STEP(16)) dut (
    .clk(clk), .rst(rst), .period_start(ps_one), .bus(dif.slave));
  duty_ramp #(.RAMP_DIV(2), .STEP(16)) dut_sync (
    .clk(clk), .rst(rst), .period_start(period_start), .bus(sif.slave));

  // one-clock pulse every 256 clocks, changed on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ps_cnt++;
      period_start = (ps_cnt % 256 == 0);
    end
  end
`else
  duty_ramp #(.RAMP_DIV(DIV), .STEP(16)) dut (
    .clk(clk), .rst(rst), .bus(dif.slave));
`endif

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input logic [7:0] t);
    dif.target       = t;
    dif.target_valid = 1'b1;
    cyc(1);
    dif.target_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.target = 8'd99;
    dif.target_valid = 1'b1;
    cyc(2);
    checks++;
    if ({dif.duty, dif.busy, dif.done, dif.target_ready} !== {8'd0, 3'b001}) begin
      errors++;
      $display("FAIL reset_state: got duty/busy/done/ready=%h expected %h",
               {dif.duty, dif.busy, dif.done, dif.target_ready}, {8'd0, 3'b001});
    end
    rst = 1'b0;
    dif.target_valid = 1'b0;
    cyc(5);
    checks++;
    if ({dif.duty, dif.busy, dif.done, dif.target_ready} !== {8'd0, 3'b001}) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h",
               {dif.duty, dif.busy, dif.done, dif.target_ready}, {8'd0, 3'b001});
    end
  endtask

  task automatic test_ramp_up;
    logic [9:0] exp_v;
    accept(8'd64);
    for (int k = 1; k <= 4; k++) begin
      cyc(DIV - 1);
      exp_v = {8'(16 * (k - 1)), 2'b10};
      checks++;
      if ({dif.duty, dif.busy, dif.done} !== exp_v) begin
        errors++;
        $display("FAIL ramp_up_hold k=%0d: got %h expected %h", k, {dif.duty, dif.busy, dif.done}, exp_v);
      end
      cyc(1);
      exp_v = (k < 4) ? {8'(16 * k), 2'b10} : {8'd64, 2'b01};
      checks++;
      if ({dif.duty, dif.busy, dif.done} !== exp_v) begin
        errors++;
        $display("FAIL ramp_up_tick k=%0d: got %h expected %h", k, {dif.duty, dif.busy, dif.done}, exp_v);
      end
    end
    cyc(1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd64, 2'b00}) begin
      errors++;
      $display("FAIL ramp_up_done_width: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd64, 2'b00});
    end
  endtask

  task automatic test_ramp_down;
    int exp_d [4] = '{48, 32, 16, 10};
    int prev = 64;
    logic [9:0] exp_v;
    accept(8'd10);
    for (int k = 0; k < 4; k++) begin
      cyc(DIV - 1);
      checks++;
      if (dif.duty !== 8'(prev)) begin
        errors++;
        $display("FAIL ramp_down_hold k=%0d: got %0d expected %0d", k, dif.duty, prev);
      end
      cyc(1);
      exp_v = (k < 3) ? {8'(exp_d[k]), 2'b10} : {8'(exp_d[k]), 2'b01};
      checks++;
      if ({dif.duty, dif.busy, dif.done} !== exp_v) begin
        errors++;
        $display("FAIL ramp_down_tick k=%0d: got %h expected %h", k, {dif.duty, dif.busy, dif.done}, exp_v);
      end
      prev = exp_d[k];
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++;
      if ({dif.duty, dif.busy, dif.done} !== {8'd10, 2'b00}) begin
        errors++;
        $display("FAIL ramp_down_single_done i=%0d: got %h expected %h", i, {dif.duty, dif.busy, dif.done}, {8'd10, 2'b00});
      end
    end
  endtask

  task automatic test_top_clamp;
    int i;
    accept(8'd250);
    for (i = 0; i < 100 && dif.done !== 1'b1; i++) cyc(1);
    checks++;
    if ({dif.duty, dif.done} !== {8'd250, 1'b1}) begin
      errors++;
      $display("FAIL reach_250: got duty=%0d done=%b after %0d cycles, expected 250/1", dif.duty, dif.done, i);
    end
    accept(8'd255);
    cyc(DIV - 1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd250, 2'b10}) begin
      errors++;
      $display("FAIL clamp_hold: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd250, 2'b10});
    end
    cyc(1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd255, 2'b01}) begin
      errors++;
      $display("FAIL clamp_255: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd255, 2'b01});
    end
    cyc(DIV);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd255, 2'b00}) begin
      errors++;
      $display("FAIL clamp_no_wrap: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd255, 2'b00});
    end
    accept(8'd255);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd255, 2'b01}) begin
      errors++;
      $display("FAIL same_target_done: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd255, 2'b01});
    end
    cyc(1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd255, 2'b00}) begin
      errors++;
      $display("FAIL same_target_after: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd255, 2'b00});
    end
  endtask

  task automatic test_retarget;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    accept(8'd128);
    cyc(2 * DIV);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd32, 2'b10}) begin
      errors++;
      $display("FAIL retarget_pre: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd32, 2'b10});
    end
    // accept one edge into the next tick window; the window keeps running
    accept(8'd16);
    cyc(DIV - 2);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd32, 2'b10}) begin
      errors++;
      $display("FAIL retarget_hold: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd32, 2'b10});
    end
    cyc(1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd16, 2'b01}) begin
      errors++;
      $display("FAIL retarget_tick: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd16, 2'b01});
    end
    accept(8'd64);
    cyc(1);
    accept(8'd16);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd16, 2'b01}) begin
      errors++;
      $display("FAIL retarget_to_duty: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd16, 2'b01});
    end
    cyc(1);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd16, 2'b00}) begin
      errors++;
      $display("FAIL retarget_done_width: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd16, 2'b00});
    end
    cyc(2 * DIV);
    checks++;
    if ({dif.duty, dif.busy, dif.done} !== {8'd16, 2'b00}) begin
      errors++;
      $display("FAIL retarget_stays: got %h expected %h", {dif.duty, dif.busy, dif.done}, {8'd16, 2'b00});
    end
  endtask

  task automatic test_reset_mid;
    accept(8'd128);
    cyc(2 * DIV);
    checks++;
    if ({dif.duty, dif.busy} !== {8'd48, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got %h expected %h", {dif.duty, dif.busy}, {8'd48, 1'b1});
    end
    cyc(1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dif.duty, dif.busy, dif.done, dif.target_ready} !== {8'd0, 3'b001}) begin
      errors++;
      $display("FAIL mid_async: got %h expected %h", {dif.duty, dif.busy, dif.done, dif.target_ready}, {8'd0, 3'b001});
    end
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      cyc(1);
      checks++;
      if ({dif.duty, dif.busy, dif.done} !== {8'd0, 2'b00}) begin
        errors++;
        $display("FAIL mid_after i=%0d: got %h expected %h", i, {dif.duty, dif.busy, dif.done}, {8'd0, 2'b00});
      end
    end
  endtask

`ifdef DUTY_RAMP_PERIOD_SYNC_EN
  task automatic test_period_sync;
    int   changes = 0;
    int   ps_seen = 0;
    logic edge_ps;
    logic [7:0] prev;
    sif.target = 8'd32;
    sif.target_valid = 1'b1;
    cyc(1);
    sif.target_valid = 1'b0;
    prev = sif.duty;
    for (int i = 0; i < 1500 && sif.done !== 1'b1; i++) begin
      cyc(1);
      edge_ps = period_start;
      if (edge_ps) ps_seen++;
      if (sif.duty !== prev) begin
        changes++;
        checks++;
        if ({edge_ps, 8'(ps_seen), sif.duty} !== {1'b1, 8'(2 * changes), 8'(16 * changes)}) begin
          errors++;
          $display("FAIL sync_step n=%0d: got ps=%b periods=%0d duty=%0d expected 1/%0d/%0d",
                   changes, edge_ps, ps_seen, sif.duty, 2 * changes, 16 * changes);
        end
        prev = sif.duty;
      end
    end
    checks++;
    if ({8'(changes), sif.duty, sif.done} !== {8'd2, 8'd32, 1'b1}) begin
      errors++;
      $display("FAIL sync_final: got changes=%0d duty=%0d done=%b expected 2/32/1", changes, sif.duty, sif.done);
    end
  endtask
`endif

  initial begin
    dif.target = 8'd0;
    dif.target_valid = 1'b0;
`ifdef DUTY_RAMP_PERIOD_SYNC_EN
    sif.target = 8'd0;
    sif.target_valid = 1'b0;
`endif
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_top_clamp();
    test_retarget();
    test_reset_mid();
`ifdef DUTY_RAMP_PERIOD_SYNC_EN
    test_period_sync();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
